// File: rtl/rc4_ksa_engine.sv
// rc4_ksa_engine: RC4 key scheduling (optional identity fill, then swap loop)
// driving an external 256x8 single-port synchronous S-box RAM.
module rc4_ksa_engine #(
  parameter int KEY_BYTES = 3,
  parameter int KEY_W     = 8*KEY_BYTES,
  parameter int KLEN_W    = $clog2(KEY_BYTES)+1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              init_en,
  input  logic [KLEN_W-1:0] key_len,
  input  logic [KEY_W-1:0]  secret_key,
  input  logic [7:0]        q_s,
  output logic [7:0]        addr_s,
  output logic [7:0]        data_s,
  output logic              wren_s,
  output logic              busy,
  output logic              done
);
  typedef enum logic [3:0] {IDLE, FILL, RD_I, CAP_I, RD_J, CAP_J, WR_I, WR_J, DONE} state_e;
  localparam logic [KLEN_W-1:0] KMAX = KLEN_W'(KEY_BYTES);
  state_e state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, kbyte;
  logic [KLEN_W-1:0] kidx_q, kidx_d, klen_q, klen_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic accept;
  assign accept = start && (state_q == IDLE || state_q == DONE);
  always_comb begin
    kbyte = '0;
    for (int k = 0; k < KEY_BYTES; k++)
      if (kidx_q == KLEN_W'(k)) kbyte = key_q[KEY_W-1-8*k -: 8];
  end
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    kidx_d  = kidx_q;
    klen_d  = klen_q;
    key_d   = key_q;
    if (accept) begin
      key_d   = secret_key;
      klen_d  = (key_len == '0 || key_len > KMAX) ? KMAX : key_len;
      i_d     = '0;
      j_d     = '0;
      kidx_d  = '0;
      state_d = init_en ? FILL : RD_I;
    end else begin
      case (state_q)
        FILL: begin
          i_d     = i_q + 8'd1;
          state_d = (i_q == 8'hff) ? RD_I : FILL;
        end
        RD_I:  state_d = CAP_I;
        CAP_I: begin
          si_d    = q_s;
          j_d     = j_q + q_s + kbyte;
          state_d = RD_J;
        end
        RD_J:  state_d = CAP_J;
        CAP_J: begin
          sj_d    = q_s;
          state_d = WR_I;
        end
        WR_I:  state_d = WR_J;
        WR_J: begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == klen_q - 1'b1) ? '0 : kidx_q + 1'b1;
          state_d = (i_q == 8'hff) ? DONE : RD_I;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      kidx_q  <= '0;
      klen_q  <= KMAX;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      kidx_q  <= kidx_d;
      klen_q  <= klen_d;
      key_q   <= key_d;
    end
  end
  // Outputs decode from state alone so an async reset clears wren_s at once.
  assign wren_s = state_q inside {FILL, WR_I, WR_J};
  assign addr_s = (state_q inside {RD_J, CAP_J, WR_J}) ? j_q :
                  (state_q inside {FILL, RD_I, CAP_I, WR_I}) ? i_q : 8'h00;
  assign data_s = (state_q == FILL) ? i_q :
                  (state_q == WR_I) ? sj_q :
                  (state_q == WR_J) ? si_q : 8'h00;
  assign busy   = !(state_q inside {IDLE, DONE});
  assign done   = state_q == DONE;
endmodule

// File: doc/rc4_ksa_engine.md
Name: rc4_ksa_engine

Overview:
Parametrised RC4 key-scheduling engine that drives a 256x8 single-port synchronous S-box RAM.
- Optionally fills the RAM with the identity permutation s[i]=i.
- Then runs the full KSA swap loop with a key whose length is selectable at run time, up to KEY_BYTES bytes.
- A start/busy/done handshake lets a cracking or decrypt controller launch it repeatedly with new keys without a reset.

Parameters:
KEY_BYTES, 3, maximum key length in bytes (1..16)
KEY_W, 8*KEY_BYTES, width of secret_key (derived; do not override)
KLEN_W, $clog2(KEY_BYTES)+1, width of key_len

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  launch request; sampled only in IDLE or DONE
init_en  input  1  1 = run the identity-fill phase before the KSA
key_len  input  KLEN_W  active key length in bytes; 0 or >KEY_BYTES treated as KEY_BYTES
secret_key  input  KEY_W  key; byte k = secret_key[KEY_W-1-8k -: 8] (byte 0 is the MSB byte)
q_s  input  8  RAM read data; valid the cycle after its address is driven
addr_s  output  8  RAM address
data_s  output  8  RAM write data
wren_s  output  1  RAM write enable
busy  output  1  high while fill or KSA is in progress
done  output  1  level; high from completion until the next accepted start

Behaviour:
Interface:
- One clock; reset is asynchronous and active-high.
- Reset values: state=IDLE; addr_s=0, data_s=0, wren_s=0, busy=0, done=0; i=0, j=0, key index=0.

Start handshake:
- start=1 in IDLE or DONE is accepted at that edge.
- On acceptance: latch secret_key and the effective key_len; clear i, j, key index and done; set busy.
- Go to FILL if init_en=1, otherwise to RD_I.
- start while busy is ignored. The latched key is immune to input changes during the run.

States:
- IDLE: outputs 0; waits for start.
- FILL: wren_s=1, addr_s=i, data_s=i, i++.
  - After i=255 is written, i wraps to 0 and the state goes to RD_I.
  - 256 cycles.
- RD_I: addr_s=i, wren_s=0.
- CAP_I:
  - register si=q_s;
  - j <= j + q_s + keybyte[kidx], modulo 256 (8-bit wrap).
- RD_J: addr_s=j.
- CAP_J: register sj=q_s.
- WR_I: wren_s=1, addr_s=i, data_s=sj.
- WR_J: wren_s=1, addr_s=j, data_s=si.
  - Advance i; kidx = (kidx==klen-1) ? 0 : kidx+1 (counter, no modulo operator).
  - If i was 255, go to DONE; otherwise go to RD_I.
- DONE: done=1, busy=0, outputs 0; accepts start.

Timing:
- KSA = 6 cycles per i, 1536 cycles total.
- With the start edge as cycle 0:
  - init_en=0: busy is high in cycles 1..1536; done is high from cycle 1537.
  - init_en=1: busy is high in cycles 1..1792; done is high from cycle 1793.

Boundary conditions:
- i==j: WR_I writes s[j] and WR_J writes si to the same address. The final value is the original s[i], which is correct.
- j arithmetic wraps modulo 256.
- key_len=1 uses byte 0 for every i.
- kidx restarts at 0 on every accepted start.
- Reset mid-run: immediate return to IDLE with wren_s=0 asynchronously. RAM contents are undefined until the next run.
- No write is issued outside FILL, WR_I and WR_J.

Test Plan:
1. Reset asserted mid-KSA (cycle 700) -> wren_s, busy, done = 0 in the same cycle. Then a start with init_en=1 -> done at cycle 1793, correct S-box.
2. init_en=1, key_len=1, secret_key byte0=0x00 -> FILL writes addr n data n for n=0..255, done at cycle 1793. Required KSA write trace:
   - i=0: addr 0 data 0, addr 0 data 0.
   - i=1: addr 1 data 1, addr 1 data 1.
   - i=2: addr 2 data 3, addr 3 data 2.
3. init_en=1, KEY_BYTES=3, key=0x0102FF, key_len=3 -> final RAM equals the software RC4 KSA reference for key {01,02,FF}. Same run with key_len=1 equals the reference for key {01}. Same run with key_len=0 equals the key_len=3 result.
4. init_en=0 after run 3, key 0x000000 -> busy for exactly 1536 cycles, done at cycle 1537. Final RAM equals the software KSA applied to the prior S-box contents.
5. start pulsed while busy at cycles 10 and 500, key input changed at cycle 20 -> no restart; the result matches the key latched at cycle 0. start in DONE -> done drops next cycle and a new run begins.
